soc_run_monitor: RTL and testbench

//  Synthesizable run controller and write tracer that sits beside the SoC CPU.
//  It issues the start pulse and counts run cycles until finish or a programmable timeout.
//  It records every CPU memory write (addr/data) into a FIFO.

---
 rtl/soc_run_monitor.sv | 177 +++++++++++++++++
 tb/tb_soc_run_monitor.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_run_monitor.sv
// soc_run_monitor
//   Run controller and write tracer that sits beside the SoC CPU. On a go
//   request it issues a one-cycle start pulse, counts run cycles until the
//   CPU reports finish or a programmable timeout expires, and records every
//   CPU memory write issued during the run into a first-word-fall-through
//   trace FIFO.
//
//   Optional feature macro: TRACE_FILTER_EN
//     defined   : adds trace_lo/trace_hi; only writes with
//                 trace_lo <= mem_addr <= trace_hi (unsigned) are traced.
//     undefined : no filter ports; every write during a run is traced.
//
// Ports
//   clk, rst_b            clock (rising edge), asynchronous active-low reset
//   go                    run request, level-sampled in IDLE/DONE
//   timeout_cycles        run-cycle limit, 0 = unlimited
//   cpu_start             registered one-cycle start pulse to the CPU
//   cpu_finish            CPU halted
//   mem_write/addr/wdata  CPU memory write port being traced
//   trace_lo/trace_hi     address window (TRACE_FILTER_EN only)
//   busy, done, timeout   run status (START/RUN, DONE, ended by timeout)
//   cycles                RUN cycles counted, saturating
//   trace_rd              pop the trace head
//   trace_valid/addr/data head entry (show-ahead, zero when empty)
//   trace_count           entries held
//   trace_overflow        sticky: a write was dropped on a full FIFO
module soc_run_monitor #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int CNT_W       = 16,
  parameter int TRACE_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_b,
  input  logic                         go,
  input  logic [CNT_W-1:0]             timeout_cycles,
  output logic                         cpu_start,
  input  logic                         cpu_finish,
  input  logic                         mem_write,
  input  logic [ADDR_W-1:0]            mem_addr,
  input  logic [DATA_W-1:0]            mem_wdata,
`ifdef TRACE_FILTER_EN
  input  logic [ADDR_W-1:0]            trace_lo,
  input  logic [ADDR_W-1:0]            trace_hi,
`endif
  output logic                         busy,
  output logic                         done,
  output logic                         timeout,
  output logic [CNT_W-1:0]             cycles,
  input  logic                         trace_rd,
  output logic                         trace_valid,
  output logic [ADDR_W-1:0]            trace_addr,
  output logic [DATA_W-1:0]            trace_data,
  output logic [$clog2(TRACE_DEPTH):0] trace_count,
  output logic                         trace_overflow
);

  localparam int PTR_W = $clog2(TRACE_DEPTH);
  localparam int CW    = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_DONE} state_t;

  state_t            state;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [ADDR_W-1:0] addr_mem [TRACE_DEPTH];
  logic [DATA_W-1:0] data_mem [TRACE_DEPTH];

  logic              addr_ok, clear, push_req, pop_req, full, do_push;
  logic [CNT_W:0]    cycles_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
`ifdef TRACE_FILTER_EN
    addr_ok = (mem_addr >= trace_lo) && (mem_addr <= trace_hi);
`else
    addr_ok = 1'b1;
`endif
    clear      = go && ((state == S_IDLE) || (state == S_DONE));
    push_req   = mem_write && busy && addr_ok;
    pop_req    = trace_rd && (trace_count != '0);
    full       = (trace_count == CW'(TRACE_DEPTH));
    // A full FIFO still accepts a push when the head leaves on the same edge.
    do_push    = push_req && (!full || pop_req);
    // One bit wider so the timeout compare never sees a wrapped count.
    cycles_inc = {1'b0, cycles} + (CNT_W+1)'(1);
  end

  // Run controller; status outputs are registered alongside the state.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= S_IDLE;
      cpu_start <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      cycles    <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (go) begin
            state     <= S_START;
            cpu_start <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            timeout   <= 1'b0;
            cycles    <= '0;
          end
        end
        S_START: begin
          state     <= S_RUN;
          cpu_start <= 1'b0;
        end
        S_RUN: begin
          if (cpu_finish) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cycles <= sat_inc(cycles);
            if ((timeout_cycles != '0) && (cycles_inc == {1'b0, timeout_cycles})) begin
              state   <= S_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              timeout <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Trace FIFO control: pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      trace_count    <= '0;
      trace_overflow <= 1'b0;
    end else if (clear) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      trace_count    <= '0;
      trace_overflow <= 1'b0;
    end else begin
      if (push_req && full && !pop_req)
        trace_overflow <= 1'b1;
      if (do_push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_req)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, pop_req})
        2'b10:   trace_count <= trace_count + CW'(1);
        2'b01:   trace_count <= trace_count - CW'(1);
        default: trace_count <= trace_count;
      endcase
    end
  end

  // Trace storage; contents are only visible through the occupancy-gated head.
  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      addr_mem[wr_ptr] <= mem_addr;
      data_mem[wr_ptr] <= mem_wdata;
    end
  end

  always_comb begin
    trace_valid = (trace_count != '0);
    trace_addr  = trace_valid ? addr_mem[rd_ptr] : '0;
    trace_data  = trace_valid ? data_mem[rd_ptr] : '0;
  end

endmodule

// File: tb/tb_soc_run_monitor.sv
module tb_soc_run_monitor;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int CNT_W  = 16;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              rst_b = 1'b1;
  logic              go = 1'b0;
  logic [CNT_W-1:0]  timeout_cycles = '0;
  logic              cpu_start;
  logic              cpu_finish = 1'b0;
  logic              mem_write = 1'b0;
  logic [ADDR_W-1:0] mem_addr = '0;
  logic [DATA_W-1:0] mem_wdata = '0;
  logic [ADDR_W-1:0] trace_lo = '0;
  logic [ADDR_W-1:0] trace_hi = '1;
  logic              busy, done, timeout;
  logic [CNT_W-1:0]  cycles;
  logic              trace_rd = 1'b0;
  logic              trace_valid;
  logic [ADDR_W-1:0] trace_addr;
  logic [DATA_W-1:0] trace_data;
  logic [$clog2(DEPTH):0] trace_count;
  logic              trace_overflow;

  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  logic [ADDR_W+DATA_W-1:0] exp;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  soc_run_monitor #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .TRACE_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_b(rst_b), .go(go), .timeout_cycles(timeout_cycles),
    .cpu_start(cpu_start), .cpu_finish(cpu_finish), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
`ifdef TRACE_FILTER_EN
    .trace_lo(trace_lo), .trace_hi(trace_hi),
`endif
    .busy(busy), .done(done), .timeout(timeout), .cycles(cycles),
    .trace_rd(trace_rd), .trace_valid(trace_valid), .trace_addr(trace_addr),
    .trace_data(trace_data), .trace_count(trace_count), .trace_overflow(trace_overflow)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    go = 0; cpu_finish = 0; mem_write = 0; trace_rd = 0; timeout_cycles = '0;
    trace_lo = '0; trace_hi = '1;
    exp_q.delete();
    rst_b = 1'b1;
    #1 rst_b = 1'b0;
    repeat (3) tick();
    rst_b = 1'b1;
    tick();
  endtask

  task automatic start_run;
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic test_reset;
    int pulses;
    do_reset();
    n_tests++; if ({cpu_start, busy, done, timeout} !== 4'b0) begin n_fail++;
      $display("FAIL reset_status: got %b want 0000", {cpu_start, busy, done, timeout}); end
    n_tests++; if (cycles !== '0) begin n_fail++; $display("FAIL reset_cycles: got %0d want 0", cycles); end
    n_tests++; if ({trace_valid, trace_count, trace_overflow} !== '0) begin n_fail++;
      $display("FAIL reset_fifo: valid=%b count=%0d ovf=%b want 0", trace_valid, trace_count, trace_overflow); end
    n_tests++; if ({trace_addr, trace_data} !== '0) begin n_fail++;
      $display("FAIL reset_head: got %h want 0", {trace_addr, trace_data}); end
    start_run();
    n_tests++; if ({cpu_start, busy} !== 2'b11) begin n_fail++;
      $display("FAIL start_pulse: start/busy=%b want 11", {cpu_start, busy}); end
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      pulses += int'(cpu_start);
    end
    n_tests++; if (pulses != 0 || busy !== 1'b1) begin n_fail++;
      $display("FAIL start_once: extra pulses=%0d busy=%b want 0/1", pulses, busy); end
  endtask

  task automatic test_finish;
    do_reset();
    start_run();
    tick();
    for (int i = 0; i < 200 && done !== 1'b1; i++) begin
      mem_write = 0; cpu_finish = 0;
      if (cycles == 2) begin mem_write = 1; mem_addr = 16'h000B; mem_wdata = 16'h1234; exp_q.push_back({16'h000B, 16'h1234}); end
      if (cycles == 3) begin mem_write = 1; mem_addr = 16'h000C; mem_wdata = 16'h1236; exp_q.push_back({16'h000C, 16'h1236}); end
      if (cycles == 4) begin mem_write = 1; mem_addr = 16'h000D; mem_wdata = 16'h1236; exp_q.push_back({16'h000D, 16'h1236}); end
      if (cycles == 40) cpu_finish = 1;
      tick();
    end
    mem_write = 0; cpu_finish = 0;
    n_tests++; if ({done, busy, timeout} !== 3'b100) begin n_fail++;
      $display("FAIL finish_status: done/busy/timeout=%b want 100", {done, busy, timeout}); end
    n_tests++; if (cycles !== 16'd40) begin n_fail++; $display("FAIL finish_cycles: got %0d want 40", cycles); end
    n_tests++; if (trace_count !== 4'd3) begin n_fail++; $display("FAIL finish_count: got %0d want 3", trace_count); end
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      n_tests++; if ({trace_valid, trace_addr, trace_data} !== {1'b1, exp}) begin n_fail++;
        $display("FAIL finish_pop: got v=%b %h want v=1 %h", trace_valid, {trace_addr, trace_data}, exp); end
      trace_rd = 1; tick(); trace_rd = 0;
    end
    n_tests++; if ({trace_valid, trace_addr, trace_data} !== '0) begin n_fail++;
      $display("FAIL finish_empty: valid=%b head=%h want 0", trace_valid, {trace_addr, trace_data}); end
  endtask

  task automatic test_timeout;
    do_reset();
    timeout_cycles = 16'd20;
    start_run();
    tick();
    for (int i = 0; i < 100 && done !== 1'b1; i++) tick();
    n_tests++; if ({done, timeout, busy} !== 3'b110 || cycles !== 16'd20) begin n_fail++;
      $display("FAIL timeout_end: done/timeout/busy=%b cycles=%0d want 110/20", {done, timeout, busy}, cycles); end
    repeat (3) tick();
    n_tests++; if ({done, timeout} !== 2'b11 || cycles !== 16'd20) begin n_fail++;
      $display("FAIL timeout_hold: done/timeout=%b cycles=%0d want 11/20", {done, timeout}, cycles); end
    // Finish on the same edge the limit would be reached: finish wins.
    start_run();
    n_tests++; if ({timeout, done, cycles} !== '0) begin n_fail++;
      $display("FAIL restart_clear: timeout=%b done=%b cycles=%0d want 0", timeout, done, cycles); end
    tick();
    for (int i = 0; i < 100 && done !== 1'b1; i++) begin
      cpu_finish = (cycles == 16'd19);
      tick();
    end
    cpu_finish = 0;
    n_tests++; if ({done, timeout} !== 2'b10 || cycles !== 16'd19) begin n_fail++;
      $display("FAIL finish_wins: done/timeout=%b cycles=%0d want 10/19", {done, timeout}, cycles); end
  endtask

  task automatic test_overflow;
    logic exp_ovf;
    do_reset();
    exp_ovf = 1'b0;
    start_run();
    for (int i = 0; i < 10; i++) begin
      mem_write = 1; mem_addr = 16'h0100 + 16'(i); mem_wdata = 16'hA000 + 16'(i);
      trace_rd = (i == 0);  // pop on empty is ignored, the entry is kept
      if (exp_q.size() < DEPTH) exp_q.push_back({mem_addr, mem_wdata});
      else exp_ovf = 1'b1;
      tick();
    end
    mem_write = 0; trace_rd = 0;
    n_tests++; if (trace_count !== 4'd8 || trace_overflow !== exp_ovf) begin n_fail++;
      $display("FAIL ovf_full: count=%0d ovf=%b want 8/%b", trace_count, trace_overflow, exp_ovf); end
    n_tests++; if ({trace_addr, trace_data} !== exp_q[0]) begin n_fail++;
      $display("FAIL ovf_head: got %h want %h", {trace_addr, trace_data}, exp_q[0]); end
    mem_write = 1; mem_addr = 16'h0200; mem_wdata = 16'hBEEF; trace_rd = 1;
    void'(exp_q.pop_front());
    exp_q.push_back({16'h0200, 16'hBEEF});
    tick();
    mem_write = 0; trace_rd = 0;
    n_tests++; if (trace_count !== 4'd8 || trace_overflow !== 1'b1) begin n_fail++;
      $display("FAIL full_push_pop: count=%0d ovf=%b want 8/1", trace_count, trace_overflow); end
    cpu_finish = 1; tick(); cpu_finish = 0;
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      n_tests++; if ({trace_valid, trace_addr, trace_data} !== {1'b1, exp}) begin n_fail++;
        $display("FAIL ovf_drain: got v=%b %h want v=1 %h", trace_valid, {trace_addr, trace_data}, exp); end
      trace_rd = 1; tick(); trace_rd = 0;
    end
    trace_rd = 1; mem_write = 1; mem_addr = 16'h0300; tick(); trace_rd = 0; mem_write = 0;
    n_tests++; if (trace_valid !== 1'b0 || trace_count !== '0) begin n_fail++;
      $display("FAIL empty_rd_done_wr: valid=%b count=%0d want 0/0", trace_valid, trace_count); end
  endtask

  task automatic test_reset_midrun;
    do_reset();
    start_run();
    mem_write = 1; mem_addr = 16'h0042; mem_wdata = 16'h5555;
    tick();
    mem_write = 0;
    for (int i = 0; i < 50 && cycles != 16'd5; i++) tick();
    n_tests++; if (cycles !== 16'd5 || trace_count !== 4'd1) begin n_fail++;
      $display("FAIL midrun_pre: cycles=%0d count=%0d want 5/1", cycles, trace_count); end
    rst_b = 1'b0;
    #1;
    n_tests++; if ({cpu_start, busy, done, timeout, cycles, trace_valid, trace_count, trace_overflow} !== '0) begin n_fail++;
      $display("FAIL midrun_reset: busy=%b done=%b cycles=%0d count=%0d want 0", busy, done, cycles, trace_count); end
    tick();
    rst_b = 1'b1;
    repeat (2) tick();
    n_tests++; if ({cpu_start, busy, done, cycles} !== '0) begin n_fail++;
      $display("FAIL midrun_idle: start=%b busy=%b cycles=%0d want 0", cpu_start, busy, cycles); end
  endtask

  task automatic test_back_to_back;
    int pulses;
    do_reset();
    start_run();
    go = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      pulses += int'(cpu_start);
    end
    go = 1'b0;
    n_tests++; if (pulses != 0) begin n_fail++; $display("FAIL go_busy: pulses=%0d want 0", pulses); end
    mem_write = 1; mem_addr = 16'h0077; mem_wdata = 16'h0101; tick(); mem_write = 0;
    cpu_finish = 1; tick(); cpu_finish = 0;
    n_tests++; if (done !== 1'b1 || cycles !== 16'd10 || trace_count !== 4'd1) begin n_fail++;
      $display("FAIL b2b_done: done=%b cycles=%0d count=%0d want 1/10/1", done, cycles, trace_count); end
    go = 1'b1; trace_rd = 1'b1;
    tick();
    go = 1'b0; trace_rd = 1'b0;
    n_tests++; if ({cpu_start, busy, done} !== 3'b110 || cycles !== '0 || trace_count !== '0 || trace_valid !== 1'b0) begin n_fail++;
      $display("FAIL go_in_done: start/busy/done=%b cycles=%0d count=%0d want 110/0/0", {cpu_start, busy, done}, cycles, trace_count); end
    tick();
    n_tests++; if ({cpu_start, busy} !== 2'b01) begin n_fail++;
      $display("FAIL go_in_done_pulse: start/busy=%b want 01", {cpu_start, busy}); end
    cpu_finish = 1; tick(); cpu_finish = 0;
  endtask

`ifdef TRACE_FILTER_EN
  task automatic test_filter;
    do_reset();
    trace_lo = 16'h000C; trace_hi = 16'h000C;
    start_run();
    tick();
    mem_write = 1;
    mem_addr = 16'h000B; mem_wdata = 16'h1234; tick();
    mem_addr = 16'h000C; mem_wdata = 16'h1236; tick();
    mem_addr = 16'h000D; mem_wdata = 16'h1236; tick();
    mem_write = 0;
    n_tests++; if (trace_count !== 4'd1 || trace_overflow !== 1'b0) begin n_fail++;
      $display("FAIL filter_count: count=%0d ovf=%b want 1/0", trace_count, trace_overflow); end
    n_tests++; if ({trace_addr, trace_data} !== {16'h000C, 16'h1236}) begin n_fail++;
      $display("FAIL filter_head: got %h want 000c1236", {trace_addr, trace_data}); end
    cpu_finish = 1; tick(); cpu_finish = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_finish();
    test_timeout();
    test_overflow();
    test_reset_midrun();
    test_back_to_back();
`ifdef TRACE_FILTER_EN
    test_filter();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
